ysyx_25030085_lsu: RTL and testbench

Load/store unit directly downstream of the decoder. It consumes MemRead, MemWrite, MemOp, the ALU-computed address and rs2 data, and runs one access at a time on a valid/ready data-memory bus. It generates byte strobes and lane-replicated write data, then sign- or zero-extends load data for write-back. It also flags misaligned accesses and bus timeouts instead of issuing a bad access.

---
 rtl/ysyx_25030085_pkg.sv | 19 +
 rtl/ysyx_25030085_lsu_align.sv | 52 +++++
 rtl/ysyx_25030085_lsu.sv | 167 ++++++++++++++++
 tb/tb_ysyx_25030085_lsu.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030085_pkg.sv
// Shared definitions for the load/store unit: MemOp encodings, FSM states, datapath width.
package ysyx_25030085_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } lsu_state_e;

endpackage

// File: rtl/ysyx_25030085_lsu_align.sv
// Combinational lane logic: store strobes/replication, load extraction/extension, misalignment.
module ysyx_25030085_lsu_align
  import ysyx_25030085_pkg::*;
(
  input  logic [2:0]  mem_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    unique case (mem_op_i)
      MOP_B:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
      MOP_BU:  rdata_o = {24'b0, byte_sel};
      MOP_H:   rdata_o = {{16{half_sel[15]}}, half_sel};
      MOP_HU:  rdata_o = {16'b0, half_sel};
      default: rdata_o = rdata_i;
    endcase
  end

  // Access size comes from the low two MemOp bits; the unsigned bit only affects loads.
  always_comb begin
    unique case (mem_op_i[1:0])
      2'b00: begin
        wstrb_o    = 4'b0001 << addr_lo_i;
        wdata_o    = {4{wdata_i[7:0]}};
        misalign_o = 1'b0;
      end
      2'b01: begin
        wstrb_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      default: begin
        wstrb_o    = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: one access at a time on a valid/ready data bus, with misalignment
// rejection and a shared request/response timeout.
module ysyx_25030085_lsu
  import ysyx_25030085_pkg::*;
#(
  parameter int unsigned XLEN    = ysyx_25030085_pkg::XLEN,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      MemOp,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            out_valid,
  output logic [XLEN-1:0] rdata,
  output logic            err_misalign,
  output logic            err_bus,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      op_q, op_d;
  logic            wen_q, wen_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_mis_q, err_mis_d;
  logic            err_bus_q, err_bus_d;

  logic            accept;
  logic [7:0]      cnt_inc;
  logic            timeout_hit;
  logic [2:0]      op_sel;
  logic [1:0]      lo_sel;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_data;
  logic            misalign;

  // In IDLE the aligner sees the live request so misalignment is known at accept;
  // afterwards it works from the latched copy.
  always_comb begin
    op_sel = (state_q == StIdle) ? MemOp : op_q;
    lo_sel = (state_q == StIdle) ? addr[1:0] : addr_q[1:0];
  end

  ysyx_25030085_lsu_align u_align (
    .mem_op_i   (op_sel),
    .addr_lo_i  (lo_sel),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rdata),
    .wstrb_o    (st_wstrb),
    .wdata_o    (st_wdata),
    .rdata_o    (ld_data),
    .misalign_o (misalign)
  );

  always_comb begin
    accept      = in_valid && (MemRead || MemWrite);
    cnt_inc     = cnt_q + 8'd1;
    timeout_hit = (cnt_inc == TimeoutCnt);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    wen_d     = wen_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_mis_d = err_mis_q;
    err_bus_d = err_bus_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d    = addr;
          wdata_d   = wdata;
          op_d      = MemOp;
          wen_d     = MemWrite;
          cnt_d     = 8'd0;
          err_mis_d = misalign;
          err_bus_d = 1'b0;
          state_d   = misalign ? StDone : StReq;
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d = StResp;
          cnt_d   = 8'd0;
        end else if (timeout_hit) begin
          state_d   = StDone;
          err_bus_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StResp: begin
        if (mem_resp_valid) begin
          state_d = StDone;
          if (!wen_q) rdata_d = ld_data;
        end else if (timeout_hit) begin
          state_d   = StDone;
          err_bus_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= '0;
      wen_q     <= 1'b0;
      cnt_q     <= 8'd0;
      rdata_q   <= '0;
      err_mis_q <= 1'b0;
      err_bus_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      wen_q     <= wen_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_mis_q <= err_mis_d;
      err_bus_q <= err_bus_d;
    end
  end

  // Bus fields are forced to zero outside REQ so idle cycles show a quiet bus.
  always_comb begin
    in_ready      = (state_q == StIdle);
    out_valid     = (state_q == StDone);
    err_misalign  = (state_q == StDone) && err_mis_q;
    err_bus       = (state_q == StDone) && err_bus_q;
    rdata         = rdata_q;
    mem_req_valid = (state_q == StReq);
    mem_wen       = (state_q == StReq) && wen_q;
    mem_addr      = (state_q == StReq) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    mem_wdata     = ((state_q == StReq) && wen_q) ? st_wdata : '0;
    mem_wstrb     = ((state_q == StReq) && wen_q) ? st_wstrb : 4'b0000;
  end

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Bench for the LSU: two instances (TIMEOUT 4 and 255) share stimulus and are checked every
// cycle against a transaction-level model, plus literal expectations from hand calculation.
module tb_ysyx_25030085_lsu;

  localparam int T0 = 4;
  localparam int T1 = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, MemRead, MemWrite;
  logic [2:0]  MemOp;
  logic [31:0] addr, wdata;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_rdata;

  logic        in_ready [2];
  logic        out_valid [2];
  logic        err_misalign [2];
  logic        err_bus [2];
  logic        mem_req_valid [2];
  logic        mem_wen [2];
  logic [31:0] rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];

  always #5 clk = ~clk;

  ysyx_25030085_lsu #(.XLEN(32), .TIMEOUT(T0)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemOp(MemOp), .addr(addr), .wdata(wdata),
    .out_valid(out_valid[0]), .rdata(rdata[0]), .err_misalign(err_misalign[0]),
    .err_bus(err_bus[0]), .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr[0]), .mem_wen(mem_wen[0]), .mem_wdata(mem_wdata[0]),
    .mem_wstrb(mem_wstrb[0]), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  ysyx_25030085_lsu #(.XLEN(32), .TIMEOUT(T1)) u_dut255 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemOp(MemOp), .addr(addr), .wdata(wdata),
    .out_valid(out_valid[1]), .rdata(rdata[1]), .err_misalign(err_misalign[1]),
    .err_bus(err_bus[1]), .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr[1]), .mem_wen(mem_wen[1]), .mem_wdata(mem_wdata[1]),
    .mem_wstrb(mem_wstrb[1]), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: absolute cycle windows and expected results per instance.
  int          m_a;
  int          m_done [2];
  int          m_req_lo [2];
  int          m_req_hi [2];
  logic        m_mis [2];
  logic        m_bus [2];
  logic [31:0] m_before [2];
  logic [31:0] m_after [2];
  logic [31:0] m_rd [2];
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic        e_wen;

  // Observations for the literal checks.
  int          ov_cyc [2];
  int          n_req [2];
  logic        cap_mis [2];
  logic        cap_bus [2];
  logic        cap_wen [2];
  logic [31:0] cap_addr [2];
  logic [31:0] cap_wdata [2];
  logic [3:0]  cap_wstrb [2];

  function automatic int tmo_of(input int i);
    return (i == 0) ? T0 : T1;
  endfunction

  function automatic int size_of(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] rb);
    int unsigned sh;
    int unsigned w;
    logic [31:0] mask;
    logic [31:0] v;
    if (op == 3'b000 || op == 3'b100) begin
      sh = 8 * (a % 4);
      w  = 8;
    end else if (op == 3'b001 || op == 3'b101) begin
      sh = 16 * ((a / 2) % 2);
      w  = 16;
    end else begin
      return rb;
    end
    mask = (32'h1 << w) - 32'h1;
    v = (rb >> sh) & mask;
    if (!op[2] && v[w-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic check32(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at cycle %0d: got %h want %h", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic check1(input string nm, input int inst, input logic act, input logic exp);
    check32(nm, inst, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic model_clear();
    m_a = -100;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = -1; m_req_lo[i] = 0; m_req_hi[i] = -1;
      m_mis[i] = 1'b0; m_bus[i] = 1'b0;
      m_before[i] = '0; m_after[i] = '0; m_rd[i] = '0;
      ov_cyc[i] = -1; n_req[i] = 0;
    end
    e_addr = '0; e_wdata = '0; e_wstrb = '0; e_wen = 1'b0;
  endtask

  task automatic model_start(input logic rd, input logic wr, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rb, input int rw, input int sw);
    int sz;
    int off;
    int t;
    logic mis;
    logic ok;
    sz  = size_of(op);
    off = int'(a % 4);
    mis = (off % sz) != 0;
    m_a = cyc;
    e_wen  = wr;
    e_addr = a & 32'hFFFF_FFFC;
    e_wstrb = '0;
    e_wdata = '0;
    if (wr) begin
      for (int j = 0; j < 4; j++) begin
        e_wstrb[j] = (j >= off) && (j < off + sz);
        e_wdata[8*j +: 8] = wd[8*(j % sz) +: 8];
      end
    end
    for (int i = 0; i < 2; i++) begin
      t = tmo_of(i);
      ov_cyc[i] = -1; n_req[i] = 0;
      m_mis[i] = 1'b0; m_bus[i] = 1'b0;
      m_req_lo[i] = 0; m_req_hi[i] = -1;
      ok = 1'b0;
      if (!(rd || wr)) begin
        m_done[i] = -1;
      end else if (mis) begin
        m_done[i] = m_a + 1;
        m_mis[i] = 1'b1;
      end else if (rw >= t) begin
        m_req_lo[i] = m_a + 1; m_req_hi[i] = m_a + t;
        m_done[i] = m_a + t + 1;
        m_bus[i] = 1'b1;
      end else begin
        m_req_lo[i] = m_a + 1; m_req_hi[i] = m_a + 1 + rw;
        if (sw >= 0 && sw < t) begin
          m_done[i] = m_a + 3 + rw + sw;
          ok = 1'b1;
        end else begin
          m_done[i] = m_a + 2 + rw + t;
          m_bus[i] = 1'b1;
        end
      end
      m_before[i] = m_rd[i];
      m_after[i]  = (ok && rd && !wr) ? load_val(op, a, rb) : m_rd[i];
      m_rd[i]     = m_after[i];
    end
  endtask

  // Per-cycle comparison against the model, plus capture for the literal checks.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int i = 0; i < 2; i++) begin
        automatic logic fin   = (cyc == m_done[i]);
        automatic logic busy  = (cyc > m_a) && (cyc <= m_done[i]);
        automatic logic inreq = (cyc >= m_req_lo[i]) && (cyc <= m_req_hi[i]);
        automatic logic [31:0] exp_rd =
            (m_done[i] >= 0 && cyc >= m_done[i]) ? m_after[i] : m_before[i];
        check1("out_valid", i, out_valid[i], fin);
        check1("in_ready", i, in_ready[i], !busy);
        check1("err_misalign", i, err_misalign[i], fin && m_mis[i]);
        check1("err_bus", i, err_bus[i], fin && m_bus[i]);
        check32("rdata", i, rdata[i], exp_rd);
        check1("mem_req_valid", i, mem_req_valid[i], inreq);
        check32("mem_addr", i, mem_addr[i], inreq ? e_addr : 32'h0);
        check1("mem_wen", i, mem_wen[i], inreq && e_wen);
        check32("mem_wdata", i, mem_wdata[i], inreq ? e_wdata : 32'h0);
        check32("mem_wstrb", i, {28'b0, mem_wstrb[i]}, {28'b0, inreq ? e_wstrb : 4'b0});
        if (out_valid[i]) begin
          ov_cyc[i] = cyc; cap_mis[i] = err_misalign[i]; cap_bus[i] = err_bus[i];
        end
        if (mem_req_valid[i]) begin
          n_req[i]++;
          cap_addr[i] = mem_addr[i]; cap_wdata[i] = mem_wdata[i];
          cap_wstrb[i] = mem_wstrb[i]; cap_wen[i] = mem_wen[i];
        end
      end
    end
  end

  // Scripted bus: ready pulses rw cycles into REQ, response sw cycles into RESP (sw<0: never).
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rb,
                        input int rw, input int sw);
    int last;
    int k;
    @(posedge clk); #1;
    model_start(rd, wr, op, a, wd, rb, rw, sw);
    in_valid = 1'b1; MemRead = rd; MemWrite = wr; MemOp = op; addr = a; wdata = wd;
    mem_rdata = rb;
    last = (m_done[0] > m_done[1]) ? m_done[0] : m_done[1];
    if (last < 0) last = m_a + 3;
    for (int s = 0; s <= last - m_a; s++) begin
      @(posedge clk); #1;
      k = cyc - m_a;
      in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemOp = ~op; addr = ~a; wdata = ~wd;
      mem_req_ready  = (k == 1 + rw);
      mem_resp_valid = (sw >= 0) && (k == 2 + rw + sw);
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemOp = 3'b0;
    addr = '0; wdata = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    model_clear();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check1("rst_in_ready", i, in_ready[i], 1'b1);
      check1("rst_out_valid", i, out_valid[i], 1'b0);
      check1("rst_req_valid", i, mem_req_valid[i], 1'b0);
      check32("rst_rdata", i, rdata[i], 32'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk_en = 1'b1;

    // lb / lbu on the top byte, zero-wait bus
    run_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0);
    check32("lb_latency", 0, ov_cyc[0] - m_a, 32'd3);
    check32("lb_rdata", 0, rdata[0], 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0);
    check32("lbu_rdata", 1, rdata[1], 32'h0000_0080);

    // in_valid without enables is ignored
    run_op(1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 32'h1111_1111, 0, 0);
    check32("noop_no_done", 0, ov_cyc[0], 32'hFFFF_FFFF);

    // sh to upper half
    run_op(1'b0, 1'b1, 3'b001, 32'h8000_0102, 32'h0000_BEEF, 32'h0, 0, 0);
    check32("sh_addr", 0, cap_addr[0], 32'h8000_0100);
    check32("sh_wstrb", 0, {28'b0, cap_wstrb[0]}, 32'hC);
    check32("sh_wdata", 0, cap_wdata[0], 32'hBEEF_BEEF);
    check1("sh_wen", 0, cap_wen[0], 1'b1);

    // misaligned lw: no bus activity, one-cycle completion
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h2222_2222, 0, 0);
    check32("mis_nreq", 0, n_req[0], 32'd0);
    check32("mis_latency", 0, ov_cyc[0] - m_a, 32'd1);
    check1("mis_flag", 0, cap_mis[0], 1'b1);

    // ready held low 5 cycles: long timeout completes, short timeout expires in REQ
    run_op(1'b0, 1'b1, 3'b010, 32'h8000_0200, 32'h1234_5678, 32'h0, 5, 0);
    check32("stall_latency", 1, ov_cyc[1] - m_a, 32'd8);
    check1("stall_no_err", 1, cap_bus[1], 1'b0);
    check32("stall_req_cycles", 1, n_req[1], 32'd6);
    check32("stall_tmo_latency", 0, ov_cyc[0] - m_a, 32'd5);
    check1("stall_tmo_err", 0, cap_bus[0], 1'b1);

    // assorted patterns
    run_op(1'b1, 1'b0, 3'b001, 32'h8000_0006, 32'h0, 32'h8001_7FFF, 0, 2);
    check32("lh_rdata", 0, rdata[0], 32'hFFFF_8001);
    run_op(1'b1, 1'b0, 3'b101, 32'h8000_0004, 32'h0, 32'h0000_F00F, 1, 0);
    check32("lhu_rdata", 0, rdata[0], 32'h0000_F00F);
    run_op(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h0, 0, 0);
    check32("sb_wstrb", 0, {28'b0, cap_wstrb[0]}, 32'h2);
    check32("sb_wdata", 0, cap_wdata[0], 32'hABAB_ABAB);
    run_op(1'b0, 1'b1, 3'b111, 32'h8000_000C, 32'hCAFE_1234, 32'h0, 0, 3);
    check32("sw111_wstrb", 0, {28'b0, cap_wstrb[0]}, 32'hF);
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 0, 3);
    check32("lw_rdata", 0, rdata[0], 32'hDEAD_BEEF);
    run_op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0);

    // response never arrives: both time out, rdata keeps the last load
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h5555_5555, 0, -1);
    check32("tmo_latency", 0, ov_cyc[0] - m_a, 32'd6);
    check1("tmo_err", 0, cap_bus[0], 1'b1);
    check32("tmo_rdata", 0, rdata[0], 32'h0000_0080);
    check32("tmo255_latency", 1, ov_cyc[1] - m_a, 32'd257);

    // asynchronous reset while waiting in RESP
    chk_en = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; MemRead = 1'b1; MemOp = 3'b010; addr = 32'h8000_0010;
    mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    in_valid = 1'b0; MemRead = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check1("arst_in_ready", i, in_ready[i], 1'b1);
      check1("arst_out_valid", i, out_valid[i], 1'b0);
      check1("arst_req_valid", i, mem_req_valid[i], 1'b0);
      check32("arst_rdata", i, rdata[i], 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1 chk_en = 1'b1;
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 0, 0);
    check32("post_rst_lw", 0, rdata[0], 32'hCAFE_F00D);
    check32("post_rst_latency", 1, ov_cyc[1] - m_a, 32'd3);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
